// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI-flash-style target answering READ (0x03) and JEDEC ID (0x9F) from a preloadable byte memory.
// Latency: SPI pins are 2-FF synchronised; edge pulses land 3 core_clk cycles after the pin edge, MISO one cycle after that.
// Backpressure: none; the SPI master paces everything, and each spi_clk phase must last at least 4 core_clk cycles.
module spi_flash_responder #(
  parameter int          DEPTH    = 256,
  parameter int          ADDR_W   = 8,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic              core_clk,
  input  logic              core_rst,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_sdoenb,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              cmd_done,
  output logic [7:0]        last_cmd
);

  typedef enum logic [2:0] {
    S_WAIT_CS_HIGH,
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_ID,
    S_IGNORE
  } state_t;

  // [0] first sync stage, [1] second sync stage, [2] edge-detect history
  logic [2:0] clk_sync_q;
  logic [2:0] cs_sync_q;
  logic [1:0] mosi_sync_q;

  logic [7:0] mem [DEPTH];

  state_t            state_q,    state_d;
  logic [4:0]        bit_cnt_q,  bit_cnt_d;
  logic [6:0]        rx_sh_q,    rx_sh_d;
  logic [ADDR_W-1:0] idx_q,      idx_d;
  logic [7:0]        tx_sh_q,    tx_sh_d;
  logic [2:0]        tx_cnt_q,   tx_cnt_d;
  logic              miso_q,     miso_d;
  logic              sdoenb_q,   sdoenb_d;
  logic              busy_q,     busy_d;
  logic              cmd_done_q, cmd_done_d;
  logic [7:0]        last_cmd_q, last_cmd_d;
  logic              cmd_seen_q, cmd_seen_d;

  logic              mosi_s, spi_rise, spi_fall, cs_s, cs_rise, cs_fall;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] idx_next, addr_next, id_sel;

  assign mosi_s   = mosi_sync_q[1];
  assign spi_rise =  clk_sync_q[1] & ~clk_sync_q[2];
  assign spi_fall = ~clk_sync_q[1] &  clk_sync_q[2];
  assign cs_s     = cs_sync_q[1];
  assign cs_rise  =  cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall  = ~cs_sync_q[1] &  cs_sync_q[2];

  // Synchronise the asynchronous SPI pins; cs resets low so WAIT_CS_HIGH sees a real deselect before decoding
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      clk_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[1:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
    end
  end

  // Preload port; contents survive reset
  always_ff @(posedge core_clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Frame decode, address capture and response shifting
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sh_d    = rx_sh_q;
    idx_d      = idx_q;
    tx_sh_d    = tx_sh_q;
    tx_cnt_d   = tx_cnt_q;
    miso_d     = miso_q;
    sdoenb_d   = sdoenb_q;
    busy_d     = busy_q;
    cmd_done_d = 1'b0;
    last_cmd_d = last_cmd_q;
    cmd_seen_d = cmd_seen_q;
    rx_byte    = {rx_sh_q, mosi_s};
    idx_next   = idx_q + 1'b1;
    addr_next  = {idx_q[ADDR_W-2:0], mosi_s};
    // ID byte counter saturates at 3 so the stream stays 0x00 forever
    id_sel     = (idx_q == ADDR_W'(3)) ? idx_q : idx_next;

    case (state_q)
      S_WAIT_CS_HIGH: begin
        if (cs_s) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (cs_fall) begin
          state_d    = S_CMD;
          bit_cnt_d  = '0;
          busy_d     = 1'b1;
          cmd_seen_d = 1'b0;
        end
      end
      S_CMD: begin
        if (spi_rise) begin
          rx_sh_d   = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d  = '0;
            last_cmd_d = rx_byte;
            cmd_seen_d = 1'b1;
            tx_cnt_d   = '0;
            idx_d      = '0;
            if (rx_byte == 8'h03) begin
              state_d = S_ADDR;
            end else if (rx_byte == 8'h9F) begin
              state_d = S_ID;
              tx_sh_d = JEDEC_ID[23:16];
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
      end
      S_ADDR: begin
        if (spi_rise) begin
          idx_d     = addr_next;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            tx_sh_d  = mem[addr_next];
            tx_cnt_d = '0;
            state_d  = S_DATA;
          end
        end
      end
      S_DATA, S_ID: begin
        if (spi_fall) begin
          miso_d   = tx_sh_q[7];
          sdoenb_d = 1'b0;
          tx_sh_d  = {tx_sh_q[6:0], 1'b0};
          tx_cnt_d = tx_cnt_q + 3'd1;
          if (tx_cnt_q == 3'd7) begin
            if (state_q == S_DATA) begin
              idx_d   = idx_next;
              tx_sh_d = mem[idx_next];
            end else begin
              idx_d = id_sel;
              if (id_sel == ADDR_W'(1))      tx_sh_d = JEDEC_ID[15:8];
              else if (id_sel == ADDR_W'(2)) tx_sh_d = JEDEC_ID[7:0];
              else                           tx_sh_d = 8'h00;
            end
          end
        end
      end
      default: begin
        // S_IGNORE: hold MISO quiet until deselect
      end
    endcase

    // Deselect ends any active frame and drops partial bits
    if (cs_rise && (state_q != S_WAIT_CS_HIGH) && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      sdoenb_d   = 1'b1;
      miso_d     = 1'b0;
      busy_d     = 1'b0;
      cmd_done_d = cmd_seen_d;
    end
  end

  // Register state and all outputs
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q    <= S_WAIT_CS_HIGH;
      bit_cnt_q  <= '0;
      rx_sh_q    <= '0;
      idx_q      <= '0;
      tx_sh_q    <= '0;
      tx_cnt_q   <= '0;
      miso_q     <= 1'b0;
      sdoenb_q   <= 1'b1;
      busy_q     <= 1'b0;
      cmd_done_q <= 1'b0;
      last_cmd_q <= 8'h00;
      cmd_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sh_q    <= rx_sh_d;
      idx_q      <= idx_d;
      tx_sh_q    <= tx_sh_d;
      tx_cnt_q   <= tx_cnt_d;
      miso_q     <= miso_d;
      sdoenb_q   <= sdoenb_d;
      busy_q     <= busy_d;
      cmd_done_q <= cmd_done_d;
      last_cmd_q <= last_cmd_d;
      cmd_seen_q <= cmd_seen_d;
    end
  end

  assign spi_miso   = miso_q;
  assign spi_sdoenb = sdoenb_q;
  assign busy       = busy_q;
  assign cmd_done   = cmd_done_q;
  assign last_cmd   = last_cmd_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed SPI master driving READ, JEDEC ID, unknown-command, reset and abort frames.
// Latency: each spi_clk phase lasts 8 core_clk cycles, giving the responder's synchronisers ample margin.
// Backpressure: none; the bench paces the bus and samples MISO on spi_clk rising edges.
module tb_spi_flash_responder;

  localparam int HALF = 80;

  logic       core_clk  = 1'b0;
  logic       core_rst  = 1'b1;
  logic       spi_clk   = 1'b0;
  logic       spi_cs_n  = 1'b1;
  logic       spi_mosi  = 1'b0;
  logic       mem_we    = 1'b0;
  logic [7:0] mem_addr  = 8'h00;
  logic [7:0] mem_wdata = 8'h00;
  logic       spi_miso;
  logic       spi_sdoenb;
  logic       busy;
  logic       cmd_done;
  logic [7:0] last_cmd;

  int tests_run = 0;
  int tests_failed = 0;

  // Counters maintained by the monitor only
  int cmd_done_cnt = 0;
  int oe_low_in    = 0;
  int oe_low_out   = 0;
  int busy_gap     = 0;

  // Windows set by the stimulus
  logic resp_phase   = 1'b0;
  logic frame_active = 1'b0;

  spi_flash_responder #(
    .DEPTH(256),
    .ADDR_W(8),
    .JEDEC_ID(24'hEF4016)
  ) dut (
    .core_clk  (core_clk),
    .core_rst  (core_rst),
    .spi_clk   (spi_clk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .spi_sdoenb(spi_sdoenb),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .cmd_done  (cmd_done),
    .last_cmd  (last_cmd)
  );

  always #5 core_clk = ~core_clk;

  // Observe outputs half a cycle away from the active edge
  always @(negedge core_clk) begin
    if (cmd_done) cmd_done_cnt <= cmd_done_cnt + 1;
    if (!spi_sdoenb) begin
      if (resp_phase) oe_low_in  <= oe_low_in + 1;
      else            oe_low_out <= oe_low_out + 1;
    end
    if (frame_active && !busy) busy_gap <= busy_gap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mem_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge core_clk);
    mem_we    = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    @(negedge core_clk);
    mem_we    = 1'b0;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = tx[i];
      #HALF;
      spi_clk  = 1'b1;
      rx[i]    = spi_miso;
      #HALF;
      spi_clk  = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic cs_low();
    @(negedge core_clk);
    spi_cs_n = 1'b0;
    #HALF;
    frame_active = 1'b1;
  endtask

  task automatic cs_high();
    #HALF;
    frame_active = 1'b0;
    spi_cs_n     = 1'b1;
    repeat (10) @(negedge core_clk);
    resp_phase   = 1'b0;
  endtask

  task automatic read_frame(input logic [23:0] addr, input int nbytes, output logic [7:0] data [4]);
    logic [7:0] rx;
    spi_byte(8'h03, rx);
    spi_byte(addr[23:16], rx);
    spi_byte(addr[15:8], rx);
    spi_byte(addr[7:0], rx);
    resp_phase = 1'b1;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;
    for (int i = 0; i < nbytes; i++) spi_byte(8'h00, data[i]);
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] data [4];
    int c0, in0, out0, gap0;

    repeat (4) @(negedge core_clk);
    core_rst = 1'b0;
    repeat (3) @(negedge core_clk);
    chk("rst_miso",     32'(spi_miso),   32'd0);
    chk("rst_sdoenb",   32'(spi_sdoenb), 32'd1);
    chk("rst_busy",     32'(busy),       32'd0);
    chk("rst_cmd_done", 32'(cmd_done),   32'd0);
    chk("rst_last_cmd", 32'(last_cmd),   32'h00);

    // READ from address 0 across four bytes
    mem_write(8'd0, 8'h93);
    mem_write(8'd1, 8'h01);
    mem_write(8'd2, 8'h00);
    mem_write(8'd3, 8'h13);
    repeat (10) @(negedge core_clk);
    c0 = cmd_done_cnt; in0 = oe_low_in; out0 = oe_low_out;
    cs_low();
    read_frame(24'h000000, 4, data);
    cs_high();
    chk("rd0_b0", 32'(data[0]), 32'h93);
    chk("rd0_b1", 32'(data[1]), 32'h01);
    chk("rd0_b2", 32'(data[2]), 32'h00);
    chk("rd0_b3", 32'(data[3]), 32'h13);
    chk("rd0_oe_outside", 32'(oe_low_out - out0), 32'd0);
    chk("rd0_oe_driven",  32'((oe_low_in - in0) != 0), 32'd1);
    chk("rd0_cmd_done",   32'(cmd_done_cnt - c0), 32'd1);
    chk("rd0_last_cmd",   32'(last_cmd), 32'h03);

    // READ with upper address bits set, wrapping past the top of memory
    mem_write(8'd255, 8'hB5);
    mem_write(8'd0,   8'h57);
    cs_low();
    read_frame(24'h0001FF, 2, data);
    cs_high();
    chk("rdwrap_b0", 32'(data[0]), 32'hB5);
    chk("rdwrap_b1", 32'(data[1]), 32'h57);

    // JEDEC ID then zero fill
    c0 = cmd_done_cnt; out0 = oe_low_out; gap0 = busy_gap;
    cs_low();
    spi_byte(8'h9F, rx);
    resp_phase = 1'b1;
    chk("id_busy_after_cmd", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) spi_byte(8'h00, data[i]);
    chk("id_busy_end", 32'(busy), 32'd1);
    cs_high();
    chk("id_b0", 32'(data[0]), 32'hEF);
    chk("id_b1", 32'(data[1]), 32'h40);
    chk("id_b2", 32'(data[2]), 32'h16);
    chk("id_b3", 32'(data[3]), 32'h00);
    chk("id_busy_gap",    32'(busy_gap - gap0), 32'd0);
    chk("id_busy_after",  32'(busy), 32'd0);
    chk("id_oe_outside",  32'(oe_low_out - out0), 32'd0);
    chk("id_cmd_done",    32'(cmd_done_cnt - c0), 32'd1);

    // Unknown command: MISO stays quiet and undriven
    c0 = cmd_done_cnt; in0 = oe_low_in; out0 = oe_low_out;
    cs_low();
    spi_byte(8'hAB, rx);
    resp_phase = 1'b1;
    spi_byte(8'hFF, data[0]);
    spi_byte(8'hFF, data[1]);
    cs_high();
    chk("ign_b0", 32'(data[0]), 32'h00);
    chk("ign_b1", 32'(data[1]), 32'h00);
    chk("ign_oe", 32'((oe_low_in - in0) + (oe_low_out - out0)), 32'd0);
    chk("ign_last_cmd", 32'(last_cmd), 32'hAB);
    chk("ign_cmd_done", 32'(cmd_done_cnt - c0), 32'd1);

    // spi_clk toggling while deselected must not start a frame
    spi_mosi = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #HALF; spi_clk = 1'b1;
      #HALF; spi_clk = 1'b0;
    end
    repeat (5) @(negedge core_clk);
    chk("glitch_busy",     32'(busy), 32'd0);
    chk("glitch_last_cmd", 32'(last_cmd), 32'hAB);

    // Reset in the middle of a READ frame
    c0 = cmd_done_cnt; in0 = oe_low_in; out0 = oe_low_out;
    cs_low();
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    @(negedge core_clk);
    core_rst = 1'b1;
    repeat (2) @(negedge core_clk);
    core_rst = 1'b0;
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    resp_phase = 1'b1;
    spi_byte(8'h00, data[0]);
    spi_byte(8'h00, data[1]);
    cs_high();
    chk("rstmid_b0", 32'(data[0]), 32'h00);
    chk("rstmid_b1", 32'(data[1]), 32'h00);
    chk("rstmid_oe", 32'((oe_low_in - in0) + (oe_low_out - out0)), 32'd0);
    chk("rstmid_cmd_done", 32'(cmd_done_cnt - c0), 32'd0);
    chk("rstmid_last_cmd", 32'(last_cmd), 32'h00);
    cs_low();
    read_frame(24'h000000, 1, data);
    cs_high();
    chk("rstmid_clean_b0", 32'(data[0]), 32'h57);

    // Abort after four command bits
    c0 = cmd_done_cnt;
    cs_low();
    spi_bits(8'h9F, 4, rx);
    cs_high();
    chk("abort_cmd_done", 32'(cmd_done_cnt - c0), 32'd0);
    chk("abort_last_cmd", 32'(last_cmd), 32'h03);
    cs_low();
    read_frame(24'h000002, 2, data);
    cs_high();
    chk("abort_next_b0", 32'(data[0]), 32'h00);
    chk("abort_next_b1", 32'(data[1]), 32'h13);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable SPI-flash-style target that sits directly downstream of the housekeeping SPI master: consumes spi_clk/spi_cs_n/spi_mosi, returns spi_miso.
- Oversamples the SPI bus in the core_clk domain and answers READ (0x03) and JEDEC ID (0x9F) from a small byte memory preloaded by firmware or the bench.
- Gives the SPI master a self-checking, synthesizable loopback partner on the test harness, replacing the behavioural flash model.

Parameters:
- DEPTH, 256, bytes of response memory (power of two).
- ADDR_W, 8, log2(DEPTH); memory index width.
- JEDEC_ID, 24'hEF4016, three bytes returned MSB-first for command 0x9F.

Ports:
- core_clk  in  1  system clock; all logic on its rising edge.
- core_rst  in  1  synchronous, active-high reset.
- spi_clk  in  1  SPI clock from master, asynchronous, mode 0.
- spi_cs_n  in  1  chip select, active low, asynchronous.
- spi_mosi  in  1  master data out, asynchronous.
- spi_miso  out  1  target data out.
- spi_sdoenb  out  1  MISO output enable, active low (1 = tri-state).
- mem_we  in  1  write strobe for preload port.
- mem_addr  in  ADDR_W  preload address.
- mem_wdata  in  8  preload data.
- busy  out  1  high while a selected transaction is in progress.
- cmd_done  out  1  one-cycle pulse on spi_cs_n deassert ending a transaction that completed at least one command byte.
- last_cmd  out  8  last command byte received.

Behaviour:
- Reset: spi_miso=0, spi_sdoenb=1, busy=0, cmd_done=0, last_cmd=8'h00, state=WAIT_CS_HIGH. Memory contents are not reset.
- Synchronisers:
  - spi_clk, spi_cs_n and spi_mosi each pass through a 2-FF synchroniser.
  - Edge detect compares sync stage 2 against a third register.
  - Rise/fall pulses appear 3 core_clk cycles after the pin edge.
- Timing constraint: spi_clk high and low phases each ≥ 4 core_clk cycles; slower is always legal.
- Mode 0 framing:
  - Sample synchronised mosi on detected rising edge; bits MSB-first.
  - Update spi_miso on detected falling edge.
  - First response bit is driven on the falling edge after the 8th (READ: 32nd) input bit.
- States:
  - WAIT_CS_HIGH: ignore bus until synchronised cs_n = 1, then go to IDLE. This covers reset mid-transaction, so a partial frame is never decoded.
  - IDLE: cs_n falling → CMD; clear bit counter.
  - CMD: shift 8 bits; on 8th rise latch last_cmd, then:
    - 0x03 → ADDR.
    - 0x9F → ID; load JEDEC_ID[23:16].
    - anything else → IGNORE.
  - ADDR: shift 24 bits. Memory index = addr[ADDR_W-1:0]; upper bits ignored. On 24th rise, read mem[index] into the shift register and go to DATA.
  - DATA: shift out MSB-first. After each 8th falling edge of a byte, load mem[index+1]; index wraps modulo DEPTH.
  - ID: stream the 3 ID bytes, then 0x00 forever.
  - IGNORE: spi_miso=0, spi_sdoenb=1.
- Termination: synchronised cs_n rising in any state except WAIT_CS_HIGH/IDLE:
  - → IDLE, spi_sdoenb=1, spi_miso=0, partial bits discarded.
  - cmd_done pulses if last_cmd was latched during this frame.
- spi_sdoenb=0 only in DATA and ID, from the cycle the first response bit is driven.
- busy=1 from cs_n falling detect to cs_n rising detect.
- Memory:
  - Single write port; mem_we writes mem[mem_addr]=mem_wdata on the clock edge.
  - Byte loads into the shift register read the memory array. On a same-cycle write to the same address, the load sees the old value; the new value is visible from the next load.
- Glitch on spi_clk while cs_n high: ignored (no state change in IDLE).

Test Plan:
- Preload mem[0..3]=93,01,00,13; master sends 03 00 00 00 then clocks 4 bytes → MISO bytes 0x93,0x01,0x00,0x13; sdoenb low only during data; cmd_done pulses once; last_cmd=0x03.
- Preload mem[255]=0xB5, mem[0]=0x57; READ addr 0x0001FF (upper bits ignored) for 2 bytes → 0xB5 then 0x57 (wrap).
- Send 9F, clock 4 bytes → 0xEF,0x40,0x16,0x00; busy high throughout.
- Send 0xAB, clock 2 bytes → sdoenb stays 1, MISO 0; last_cmd=0xAB; cmd_done pulses.
- Assert core_rst for 2 cycles mid-READ with cs_n low, deassert, continue clocking → no response, sdoenb=1. Next clean 03 000000 frame returns mem[0] correctly.
- Raise cs_n after 4 bits of command → no cmd_done, last_cmd unchanged. Next frame 03 000002 → 0x00.
